// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem interconnect fabric and its
// stand-alone slot decoder.
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    localparam int TMO_W = 16;

    // A single-slot fabric still needs a 1-bit index to keep ports legal.
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iomem_slot_decode.sv
// Combinational address-to-slot decoder; also used by boards that decode
// peripheral selects outside the fabric.
module iomem_slot_decode
    import iomem_pkg::*;
#(
    parameter int          NSLAVES    = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          SLOT_SHIFT = 16,
    localparam int         SLOT_W     = slot_width(NSLAVES)
) (
    input  logic [31:0]       addr,
    output logic [SLOT_W-1:0] slot,
    output logic              in_range
);

    logic [31:0] offset;
    logic [31:0] slot_full;

    // Unsigned wrap below BASE_ADDR yields a huge slot, but the explicit
    // lower-bound compare keeps the intent readable.
    assign offset    = addr - BASE_ADDR;
    assign slot_full = offset >> SLOT_SHIFT;
    assign in_range  = (addr >= BASE_ADDR) && (slot_full < 32'(NSLAVES));
    assign slot      = SLOT_W'(slot_full);

endmodule

// File: rtl/iomem_fabric.sv
// Registered iomem interconnect: decodes the master request to one of
// NSLAVES slots, times out silent slaves and completes unmapped accesses.
module iomem_fabric
    import iomem_pkg::*;
#(
    parameter int          NSLAVES    = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          SLOT_SHIFT = 16,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    input  logic [3:0]              iomem_wstrb,
    output logic [31:0]             iomem_rdata,
    output logic                    iomem_err,
    output logic [NSLAVES-1:0]      s_valid,
    input  logic [NSLAVES-1:0]      s_ready,
    input  logic [32*NSLAVES-1:0]   s_rdata,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,
    output logic [7:0]              err_count
);

    localparam int               SLOT_W    = slot_width(NSLAVES);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_t            state;
    logic [SLOT_W-1:0] sel;
    logic [SLOT_W-1:0] dec_slot;
    logic              dec_in_range;
    logic [TMO_W-1:0]  tmo_cnt;

    iomem_slot_decode #(
        .NSLAVES    (NSLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .SLOT_SHIFT (SLOT_SHIFT)
    ) u_decode (
        .addr     (iomem_addr),
        .slot     (dec_slot),
        .in_range (dec_in_range)
    );

    // NOTE: every register here is state, so all assignments are
    // non-blocking; blocking ones would let later lines see updated values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            tmo_cnt     <= '0;
            iomem_ready <= 1'b0;
            iomem_err   <= 1'b0;
            iomem_rdata <= '0;
            s_valid     <= '0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_wstrb     <= '0;
            err_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (iomem_valid) begin
                        s_addr  <= iomem_addr;
                        s_wdata <= iomem_wdata;
                        s_wstrb <= iomem_wstrb;
                        sel     <= dec_slot;
                        if (dec_in_range) begin
                            s_valid <= NSLAVES'(1) << dec_slot;
                            state   <= ACCESS;
                        end else begin
                            state   <= ERR;
                        end
                    end
                end

                ACCESS: begin
                    // Abort beats completion; a ready that coincides with
                    // the timeout is still a normal completion.
                    if (!iomem_valid) begin
                        s_valid <= '0;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else if (s_ready[sel]) begin
                        iomem_rdata <= s_rdata[32*sel +: 32];
                        iomem_err   <= 1'b0;
                        iomem_ready <= 1'b1;
                        s_valid     <= '0;
                        state       <= RESP;
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        iomem_rdata <= ERR_DATA;
                        iomem_err   <= 1'b1;
                        iomem_ready <= 1'b1;
                        s_valid     <= '0;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ERR: begin
                    iomem_rdata <= ERR_DATA;
                    iomem_err   <= 1'b1;
                    iomem_ready <= 1'b1;
                    state       <= RESP;
                end

                RESP: begin
                    iomem_ready <= 1'b0;
                    iomem_err   <= 1'b0;
                    tmo_cnt     <= '0;
                    if (iomem_err && (err_count != 8'hFF))
                        err_count <= err_count + 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_fabric.sv
// Directed bench for iomem_fabric: latency, decode, timeout, abort, reset
// and error-counter saturation with hand-computed expectations.
module tb_iomem_fabric;

    logic         clk;
    logic         rst;
    logic         iomem_valid;
    logic         iomem_ready;
    logic [31:0]  iomem_addr;
    logic [31:0]  iomem_wdata;
    logic [3:0]   iomem_wstrb;
    logic [31:0]  iomem_rdata;
    logic         iomem_err;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [7:0]   err_count;

    int n_cmp = 0;
    int n_bad = 0;

    iomem_fabric #(
        .NSLAVES    (4),
        .BASE_ADDR  (32'h0300_0000),
        .SLOT_SHIFT (16),
        .TIMEOUT    (8),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_wstrb (iomem_wstrb),
        .iomem_rdata (iomem_rdata),
        .iomem_err   (iomem_err),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Master presents a request in cycle 0; the modelled slave pulses s_ready
    // in cycle rdy_cyc (negative = never). lat is the cycle iomem_ready is seen.
    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int rdy_cyc, input int slv,
                          input logic [31:0] sd, output int lat,
                          output logic [31:0] rd, output logic er,
                          output logic [3:0] sv_seen);
        iomem_addr  = a;
        iomem_wdata = wd;
        iomem_wstrb = ws;
        iomem_valid = 1'b1;
        s_rdata     = '0;
        s_rdata[32*slv +: 32] = sd;
        lat     = -1;
        rd      = '0;
        er      = 1'b0;
        sv_seen = '0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            s_ready = (c == rdy_cyc) ? 4'(1 << slv) : 4'b0000;
            tick();
            sv_seen |= s_valid;
            if (iomem_ready) begin
                lat = c + 1;
                rd  = iomem_rdata;
                er  = iomem_err;
                check("s_valid_in_resp", 32'(s_valid), 32'h0);
            end
        end
        s_ready = '0;
        tick();
        iomem_valid = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [3:0]  sv;
    logic        rdy_seen;

    initial begin
        rst         = 1'b1;
        iomem_valid = 1'b0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        iomem_wstrb = '0;
        s_ready     = '0;
        s_rdata     = '0;
        tick();
        tick();

        check("rst_ready",     32'(iomem_ready), 32'h0);
        check("rst_err",       32'(iomem_err),   32'h0);
        check("rst_rdata",     iomem_rdata,      32'h0);
        check("rst_s_valid",   32'(s_valid),     32'h0);
        check("rst_s_addr",    s_addr,           32'h0);
        check("rst_s_wdata",   s_wdata,          32'h0);
        check("rst_s_wstrb",   32'(s_wstrb),     32'h0);
        check("rst_err_count", 32'(err_count),   32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait read from slot 0
        access(32'h0300_0004, 32'h0, 4'b0000, 1, 0, 32'h1234_5678, lat, rd, er, sv);
        check("rd0_latency", 32'(lat), 32'd2);
        check("rd0_rdata",   rd,       32'h1234_5678);
        check("rd0_err",     32'(er),  32'h0);
        check("rd0_s_valid", 32'(sv),  32'h1);
        check("rd0_s_addr",  s_addr,   32'h0300_0004);

        // Write to slot 3 with five wait states
        access(32'h0303_0010, 32'hA5A5_A5A5, 4'b0011, 6, 3, 32'h0BAD_F00D, lat, rd, er, sv);
        check("wr3_latency", 32'(lat),     32'd7);
        check("wr3_s_valid", 32'(sv),      32'h8);
        check("wr3_s_wdata", s_wdata,      32'hA5A5_A5A5);
        check("wr3_s_wstrb", 32'(s_wstrb), 32'h3);
        check("wr3_s_addr",  s_addr,       32'h0303_0010);
        check("wr3_err",     32'(er),      32'h0);

        // Unmapped: slot 4, then below the base
        access(32'h0304_0000, 32'h0, 4'b0000, -1, 0, 32'h0, lat, rd, er, sv);
        check("unm4_latency", 32'(lat),       32'd2);
        check("unm4_rdata",   rd,             32'hDEAD_BEEF);
        check("unm4_err",     32'(er),        32'h1);
        check("unm4_s_valid", 32'(sv),        32'h0);
        check("unm4_count",   32'(err_count), 32'd1);
        access(32'h02FF_FFFC, 32'h0, 4'b0000, -1, 0, 32'h0, lat, rd, er, sv);
        check("unmlo_latency", 32'(lat),       32'd2);
        check("unmlo_rdata",   rd,             32'hDEAD_BEEF);
        check("unmlo_err",     32'(er),        32'h1);
        check("unmlo_s_valid", 32'(sv),        32'h0);
        check("unmlo_count",   32'(err_count), 32'd2);

        // Slave 1 never answers: TIMEOUT + 2 = 10 cycles
        access(32'h0301_0000, 32'h0, 4'b0000, -1, 1, 32'h5555_AAAA, lat, rd, er, sv);
        check("tmo_latency", 32'(lat),       32'd10);
        check("tmo_rdata",   rd,             32'hDEAD_BEEF);
        check("tmo_err",     32'(er),        32'h1);
        check("tmo_s_valid", 32'(sv),        32'h2);
        check("tmo_count",   32'(err_count), 32'd3);

        // Slave 1 answers in cycle 8: normal completion
        access(32'h0301_0008, 32'h0, 4'b0000, 8, 1, 32'h1111_2222, lat, rd, er, sv);
        check("late8_latency", 32'(lat), 32'd9);
        check("late8_rdata",   rd,       32'h1111_2222);
        check("late8_err",     32'(er),  32'h0);

        // Ready on the very edge the timeout fires: the slave wins
        access(32'h0301_000C, 32'h0, 4'b0000, 9, 1, 32'h3333_4444, lat, rd, er, sv);
        check("tie_latency", 32'(lat),       32'd10);
        check("tie_rdata",   rd,             32'h3333_4444);
        check("tie_err",     32'(er),        32'h0);
        check("tie_count",   32'(err_count), 32'd3);

        // Master abort two cycles into ACCESS on slot 2
        iomem_addr  = 32'h0302_0000;
        iomem_wstrb = 4'b0000;
        iomem_valid = 1'b1;
        tick();
        check("abort_s_valid_on", 32'(s_valid), 32'h4);
        tick();
        tick();
        iomem_valid = 1'b0;
        tick();
        check("abort_s_valid_off", 32'(s_valid), 32'h0);
        rdy_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdy_seen |= iomem_ready;
            tick();
        end
        check("abort_no_ready", 32'(rdy_seen), 32'h0);
        access(32'h0302_0020, 32'h0, 4'b0000, 2, 2, 32'hCAFE_0002, lat, rd, er, sv);
        check("after_abort_latency", 32'(lat), 32'd3);
        check("after_abort_rdata",   rd,       32'hCAFE_0002);
        check("after_abort_err",     32'(er),  32'h0);

        // Asynchronous reset in the middle of ACCESS
        iomem_addr  = 32'h0301_0000;
        iomem_valid = 1'b1;
        tick();
        tick();
        check("rstacc_s_valid_pre", 32'(s_valid), 32'h2);
        rst = 1'b1;
        #1;
        check("rstacc_s_valid", 32'(s_valid),   32'h0);
        check("rstacc_ready",   32'(iomem_ready), 32'h0);
        check("rstacc_count",   32'(err_count), 32'h0);
        iomem_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset while iomem_ready is high
        iomem_addr  = 32'h0304_0000;
        iomem_valid = 1'b1;
        tick();
        tick();
        check("rstresp_ready_pre", 32'(iomem_ready), 32'h1);
        rst = 1'b1;
        #1;
        check("rstresp_ready", 32'(iomem_ready), 32'h0);
        check("rstresp_err",   32'(iomem_err),   32'h0);
        check("rstresp_rdata", iomem_rdata,      32'h0);
        iomem_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Error counter saturation
        for (int i = 0; i < 254; i++)
            access(32'h0400_0000, 32'h0, 4'b0000, -1, 0, 32'h0, lat, rd, er, sv);
        check("sat_count_254", 32'(err_count), 32'hFE);
        for (int i = 0; i < 46; i++)
            access(32'h0400_0000, 32'h0, 4'b0000, -1, 0, 32'h0, lat, rd, er, sv);
        check("sat_count_300", 32'(err_count), 32'hFF);
        check("sat_last_err",  32'(er),        32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iomem_fabric.md
# iomem_fabric

Parametrised iomem interconnect between the SoC's iomem master port and up to NSLAVES memory-mapped peripherals (GPIO, UART, timers, …). It replaces hand-written per-board address compares and ready/rdata OR-ing with one registered decoder. It also adds behaviour the current top-level glue lacks:

- Unmapped accesses complete with an error word instead of hanging the CPU.
- Slaves that never answer are timed out.
- Errors are counted.

## Interface

Parameters:
- NSLAVES, 4: number of slave slots, 1..16.
- BASE_ADDR, 32'h0300_0000: address of slot 0; aligned to 2^SLOT_SHIFT.
- SLOT_SHIFT, 16: log2 of slot size in bytes (64 KiB per slot by default).
- TIMEOUT, 255: maximum cycles a selected slave may hold off ready, 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on error completions.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- iomem_valid, in, 1: master request; held until iomem_ready.
- iomem_ready, out, 1: one-cycle completion pulse.
- iomem_addr, in, 32: byte address.
- iomem_wdata, in, 32: write data.
- iomem_wstrb, in, 4: byte strobes; 0 = read.
- iomem_rdata, out, 32: read data, valid while iomem_ready.
- iomem_err, out, 1: high with iomem_ready when the completion is an error.
- s_valid, out, NSLAVES: one-hot slave request.
- s_ready, in, NSLAVES: per-slave completion.
- s_rdata, in, 32*NSLAVES: slave i's data at bits [32*i+31:32*i].
- s_addr, out, 32: registered request address, common to all slaves.
- s_wdata, out, 32: registered write data, common to all slaves.
- s_wstrb, out, 4: registered write strobes, common to all slaves.
- err_count, out, 8: saturating count of error completions.

## Operation

The state machine has four states: IDLE, ACCESS, RESP, ERR.

- **IDLE**
  - On iomem_valid, compute slot = (iomem_addr − BASE_ADDR) >> SLOT_SHIFT as an unsigned 32-bit subtraction. Latch addr, wdata and wstrb into s_addr, s_wdata and s_wstrb.
  - If iomem_addr ≥ BASE_ADDR and slot < NSLAVES, go to ACCESS and set s_valid[slot]. Otherwise go to ERR.
- **ACCESS**
  - s_valid[sel] is held and the timeout counter increments every cycle.
  - If s_ready[sel] is high, capture s_rdata[sel] and go to RESP.
  - Otherwise, when the counter reaches TIMEOUT, load ERR_DATA and go to RESP with the error flag set.
  - s_ready bits of unselected slaves are ignored.
  - If s_ready and timeout coincide, the slave wins: the completion is normal.
- **ERR**: load ERR_DATA, set the error flag and go to RESP. This cycle exists only so unmapped accesses take the same RESP path as mapped ones.
- **RESP**
  - iomem_ready = 1 for exactly one cycle. iomem_rdata holds the registered data and iomem_err the registered flag.
  - s_valid is already 0.
  - On the following edge go to IDLE. If the error flag is set, err_count increments, saturating at 8'hFF.
- **Master abort**: if iomem_valid drops while in ACCESS, drop s_valid on the next edge, return to IDLE and produce no iomem_ready.
- **Writes and reads** are handled identically. rdata is captured for writes too; the master ignores it.

## Timing

- **Reset values**: state IDLE; iomem_ready 0; iomem_err 0; iomem_rdata 0; s_valid 0; s_addr, s_wdata and s_wstrb 0; err_count 0; timeout counter 0.
- **Latency for a mapped access**:
  - Request sampled at edge 0; s_valid is high from edge 1.
  - If the slave responds at edge 1+k, with k ≥ 0 cycles of wait, iomem_ready is high in the cycle after edge 2+k.
  - Minimum latency is 2 cycles.
- **Latency for an unmapped access**: iomem_ready follows 2 edges after the request (IDLE→ERR→RESP).
- **Timed-out access**: completes TIMEOUT+2 cycles after the request.
- **Combinational paths**: there is no path from iomem_* inputs to any output, and none from s_ready/s_rdata to iomem_*. All outputs are flops.
- **After completion**: the master deasserts iomem_valid on the edge where it samples iomem_ready. IDLE may accept a new request on the very next edge, so there is no forced idle gap.
- **Reset mid-access**: all state clears immediately and asynchronously. s_valid drops without waiting for the slave.

## Structure

- **Package `iomem_pkg`** holds:
  - the state enum (IDLE, ACCESS, RESP, ERR);
  - the default ERR_DATA constant;
  - a slot-index width function, max(1, $clog2(NSLAVES));
  - the timeout counter width (16).
- **Sub-module `iomem_slot_decode`** is combinational. It takes the address and parameters and produces a slot index plus an in_range bit. It is reused by boards that decode outside the fabric.

## Test plan

- **Read, zero wait**: read of 32'h0300_0004, slave 0 ready on the first s_valid cycle with rdata 32'h1234_5678 → s_addr = 32'h0300_0004; iomem_ready 2 cycles after the request; iomem_rdata = 32'h1234_5678; iomem_err = 0.
- **Write, wait states**: write 32'hA5A5_A5A5 with wstrb 4'b0011 to 32'h0303_0010, slave 3 delays 5 cycles → only s_valid[3] is high; s_wdata and s_wstrb match; iomem_ready at cycle 7.
- **Unmapped addresses**: reads of 32'h0304_0000 (slot 4 with NSLAVES = 4) and 32'h02FF_FFFC → iomem_ready at cycle 2 with rdata 32'hDEAD_BEEF and iomem_err = 1; err_count goes 0→1→2; s_valid stays 0.
- **Timeout**: with TIMEOUT = 8, slave 1 never responds → error completion at cycle 10 with ERR_DATA. In a second run, the slave responds at exactly cycle 8 → normal completion with the slave's data.
- **Master abort**: iomem_valid drops 2 cycles into ACCESS → s_valid clears the next cycle; no iomem_ready; the next request to slave 2 completes normally.
- **Reset and saturation**:
  - Assert rst mid-ACCESS → s_valid and iomem_ready go to 0 asynchronously.
  - After 300 unmapped accesses → err_count = 8'hFF.
